// File: rtl/xor_stream_decryptor.sv
// Receive-side XOR stream decryptor: valid/ready in, one registered output stage, key updates ordered behind in-flight data.
// Optional build macro XOR_DEC_ROLLING_KEY_EN rotates the key left by one after every accepted byte.
module xor_stream_decryptor #(
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] KEY_DEFAULT = 8'h42,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              key_wr,
  input  logic [DATA_W-1:0] key_in,
  output logic              key_busy,
  output logic              key_err,
  output logic [CNT_W-1:0]  byte_count
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_KEY_PEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   pend_key_q, pend_key_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                key_err_q, key_err_d;
  logic [CNT_W-1:0]    byte_count_q, byte_count_d;

  logic                in_ready_w;
  logic                accept;
  logic                out_take;
  logic                key_wr_ok;
  logic                key_wr_zero;

  // Counter stops at all-ones so it can never wrap back through small values.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef XOR_DEC_ROLLING_KEY_EN
  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], v[DATA_W-1]};
  endfunction
`endif

  always_comb begin
    in_ready_w  = reset_n && (state_q == ST_RUN) && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready_w;
    out_take    = out_valid_q && out_ready;
    key_wr_ok   = key_wr && (key_in != '0);
    key_wr_zero = key_wr && (key_in == '0);
  end

  // Output register: the accepted byte always sees the key held before this edge.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    byte_count_d = byte_count_q;
    if (accept) begin
      out_data_d   = in_data ^ key_q;
      out_valid_d  = 1'b1;
      byte_count_d = sat_inc(byte_count_q);
    end else if (out_take) begin
      out_valid_d  = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    pend_key_d = pend_key_q;
    key_err_d  = key_err_q | key_wr_zero;
`ifdef XOR_DEC_ROLLING_KEY_EN
    if (accept) begin
      key_d = rotl1(key_q);
    end
`endif
    case (state_q)
      ST_RUN: begin
        if (key_wr_ok) begin
          pend_key_d = key_in;
          state_d    = ST_KEY_PEND;
        end
      end
      ST_KEY_PEND: begin
        // Load once the output register is empty or its last beat leaves; a write in this cycle is the newest value.
        if (!out_valid_q || out_take) begin
          key_d   = key_wr_ok ? key_in : pend_key_q;
          state_d = ST_RUN;
        end else if (key_wr_ok) begin
          pend_key_d = key_in;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      key_q        <= KEY_DEFAULT;
      pend_key_q   <= KEY_DEFAULT;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      key_err_q    <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      pend_key_q   <= pend_key_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      key_err_q    <= key_err_d;
      byte_count_q <= byte_count_d;
    end
  end

  always_comb begin
    in_ready   = in_ready_w;
    out_valid  = out_valid_q;
    out_data   = out_data_q;
    key_busy   = (state_q == ST_KEY_PEND);
    key_err    = key_err_q;
    byte_count = byte_count_q;
  end

endmodule

// File: tb/tb_xor_stream_decryptor.sv
// Directed bench for xor_stream_decryptor (default build, static key); a second instance with a 4-bit counter shares the stimulus.
module tb_xor_stream_decryptor;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        key_wr;
  logic [7:0]  key_in;

  logic        in_ready,  out_valid,  key_busy,  key_err;
  logic [7:0]  out_data;
  logic [15:0] byte_count;

  logic        in_ready4, out_valid4, key_busy4, key_err4;
  logic [7:0]  out_data4;
  logic [3:0]  byte_count4;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t t1[3];

  xor_stream_decryptor #(.DATA_W(8), .KEY_DEFAULT(8'h42), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_wr(key_wr), .key_in(key_in),
    .key_busy(key_busy), .key_err(key_err), .byte_count(byte_count)
  );

  xor_stream_decryptor #(.DATA_W(8), .KEY_DEFAULT(8'h42), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .key_wr(key_wr), .key_in(key_in),
    .key_busy(key_busy4), .key_err(key_err4), .byte_count(byte_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    t1[0] = '{din: 8'h18, dout: 8'h5A};
    t1[1] = '{din: 8'h00, dout: 8'h42};
    t1[2] = '{din: 8'hFF, dout: 8'hBD};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    key_wr    = 1'b0;
    key_in    = 8'h00;
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    step();
    step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_key_busy", key_busy, 1'b0);
    chk("rst_key_err", key_err, 1'b0);
    chk("rst_byte_count", byte_count, 16'd0);
    chk("rst_in_ready4", in_ready4, 1'b0);
    chk("rst_key_busy4", key_busy4, 1'b0);
    chk("rst_key_err4", key_err4, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Test 1: table-driven stream at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = t1[i].din;
      #1;
      chk("t1_in_ready", in_ready, 1'b1);
      step();
      chk("t1_out_valid", out_valid, 1'b1);
      chk("t1_out_data", out_data, t1[i].dout);
    end
    in_valid = 1'b0;
    step();
    chk("t1_drain_valid", out_valid, 1'b0);
    chk("t1_hold_data", out_data, 8'hBD);
    chk("t1_byte_count", byte_count, 16'd3);

    // Test 2: backpressure holds the output stable
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    #1;
    chk("t2_in_ready_empty", in_ready, 1'b1);
    step();
    chk("t2_out_valid", out_valid, 1'b1);
    chk("t2_out_data", out_data, 8'h53);
    in_data = 8'h22;
    #1;
    chk("t2_in_ready_stall", in_ready, 1'b0);
    step();
    step();
    chk("t2_stable_valid", out_valid, 1'b1);
    chk("t2_stable_data", out_data, 8'h53);
    chk("t2_count_stall", byte_count, 16'd4);
    out_ready = 1'b1;
    #1;
    chk("t2_in_ready_release", in_ready, 1'b1);
    step();
    chk("t2_next_data", out_data, 8'h60);
    chk("t2_count", byte_count, 16'd5);
    in_valid = 1'b0;
    step();
    chk("t2_drain_valid", out_valid, 1'b0);

    // Test 4: zero key rejected, stream keeps the old key
    key_wr = 1'b1;
    key_in = 8'h00;
    step();
    key_wr = 1'b0;
    chk("t4_key_err", key_err, 1'b1);
    chk("t4_key_busy", key_busy, 1'b0);
    chk("t4_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h18;
    step();
    in_valid = 1'b0;
    chk("t4_old_key_data", out_data, 8'h5A);
    step();
    chk("t4_err_sticky", key_err, 1'b1);

    // Test 3: key update waits for the pending output beat
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    step();
    in_valid = 1'b0;
    chk("t3_out_data", out_data, 8'h43);
    key_wr = 1'b1;
    key_in = 8'h3C;
    step();
    key_wr = 1'b0;
    chk("t3_key_busy", key_busy, 1'b1);
    chk("t3_in_ready_pend", in_ready, 1'b0);
    step();
    chk("t3_still_busy", key_busy, 1'b1);
    chk("t3_hold_data", out_data, 8'h43);
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_pend_or", in_ready, 1'b0);
    step();
    out_ready = 1'b0;
    #1;
    chk("t3_key_loaded", key_busy, 1'b0);
    chk("t3_out_drained", out_valid, 1'b0);
    chk("t3_in_ready_back", in_ready, 1'b1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    step();
    in_valid = 1'b0;
    chk("t3_new_key_data", out_data, 8'h00);
    chk("t3_count", byte_count, 16'd8);
    chk("t3_count4", byte_count4, 4'd8);
    step();

    // Test 5: narrow counter saturates at 15 while data stays correct
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(i * 37 + 5);
      step();
      chk("t5_out_data", out_data, in_data ^ 8'h3C);
      chk("t5_out_data4", out_data4, in_data ^ 8'h3C);
    end
    in_valid = 1'b0;
    chk("t5_count4_sat", byte_count4, 4'd15);
    chk("t5_count", byte_count, 16'd28);
    step();
    chk("t5_count4_hold", byte_count4, 4'd15);
    chk("t5_drain4", out_valid4, 1'b0);

    // Test 6: reset mid-operation drops output and pending key
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    step();
    in_valid = 1'b0;
    chk("t6_out_data", out_data, 8'h3C);
    key_wr = 1'b1;
    key_in = 8'h77;
    step();
    key_wr = 1'b0;
    chk("t6_busy", key_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_data", out_data, 8'h00);
    chk("t6_rst_busy", key_busy, 1'b0);
    chk("t6_rst_err", key_err, 1'b0);
    chk("t6_rst_count", byte_count, 16'd0);
    chk("t6_rst_in_ready", in_ready, 1'b0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h18;
    step();
    in_valid = 1'b0;
    chk("t6_default_key", out_data, 8'h5A);
    chk("t6_no_busy", key_busy, 1'b0);
    chk("t6_count", byte_count, 16'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_stream_decryptor.md
Name: xor_stream_decryptor

Overview:
Receive-side counterpart of the team's XOR crypto core. Takes an XOR-enciphered byte stream over a valid/ready handshake and XORs it with the shared key to recover plaintext. Key updates are ordered against in-flight data. The zero key is refused, and the byte counter saturates so that it cannot wrap into a rare-value trigger.

Parameters:
DATA_W, 8, width of data and key
KEY_DEFAULT, 8'h42, key value loaded on reset; must be non-zero
CNT_W, 16, width of the accepted-byte counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  ciphertext byte valid
in_ready  out  1  decryptor can accept a byte
in_data  in  DATA_W  ciphertext byte
out_valid  out  1  plaintext byte valid
out_ready  in  1  downstream accepts the byte
out_data  out  DATA_W  plaintext byte
key_wr  in  1  single-cycle key update request
key_in  in  DATA_W  new key value
key_busy  out  1  key update pending; stream stalled
key_err  out  1  sticky flag; a zero key was rejected
byte_count  out  CNT_W  accepted input bytes, saturating

Behaviour:
- Reset (reset_n low, async assert, sync release):
  - key=KEY_DEFAULT, state=RUN.
  - out_valid=0, out_data=0, key_busy=0, key_err=0, byte_count=0.
  - in_ready=0 while in reset.
- Datapath: one output register, latency 1 cycle.
  - Input is accepted when in_valid && in_ready.
  - On the next edge: out_data<=in_data^key, out_valid<=1.
- in_ready = (state==RUN) && (!out_valid || out_ready). Full throughput under continuous out_ready.
- Output is cleared when out_valid && out_ready && no new accept: out_valid<=0, and out_data holds its last value.
- out_data and out_valid must stay stable while out_valid && !out_ready.
- State machine:
  - RUN → KEY_PEND on key_wr with key_in!=0. key_in is latched into pend_key and key_busy=1.
  - key_wr with key_in==0: ignored, key_err<=1 (sticky until reset), state unchanged.
  - KEY_PEND: in_ready=0. When out_valid==0, or the final beat is being taken (out_valid && out_ready), then: key<=pend_key, key_busy<=0, return to RUN. in_ready rises the cycle after.
  - A key_wr arriving in KEY_PEND overwrites pend_key (last write wins). A zero value is still rejected and sets key_err.
- Simultaneous events:
  - A key_wr in the same cycle as an accepted input: the byte uses the old key, then the transition to KEY_PEND happens.
- byte_count:
  - +1 per accepted input.
  - Saturates at all-ones and does not wrap.
  - It is not cleared by a key update.
- Reset mid-operation discards the output register and any pending key. The pending key is never applied.

Optional Feature:
- Macro: XOR_DEC_ROLLING_KEY_EN.
- Defined: after each accepted byte, key <= {key[DATA_W-2:0], key[DATA_W-1]} (rotate left 1). A key load from KEY_PEND overrides the rotation in that cycle. The rotation order matches a transmitter built with the same macro.
- Undefined: the key is static between loads. No rotation logic is built.

Test Plan:
1. Reset, then stream in_data 0x18, 0x00, 0xFF with out_ready=1 → out_data 0x5A, 0x42, 0xBD, each one cycle after acceptance. byte_count=3.
2. Hold out_ready=0 after one accept → out_valid=1 and out_data stable; in_ready=0 until out_ready=1. No byte lost or duplicated.
3. key_wr key_in=0x3C while out_valid=1 and out_ready=0 → key_busy=1, in_ready=0. After out_ready pulse the key loads; next in_data 0x3C → out_data 0x00.
4. key_wr key_in=0x00 → key_err=1, key stays 0x42, stream continues. key_err persists until reset_n low.
5. CNT_W=4, feed 20 bytes → byte_count reaches 15 and holds. Decryption stays correct.
6. Assert reset_n low mid-stream with out_valid=1 and key_busy=1 → all outputs at reset values immediately. Key returns to 0x42; the pending key is not applied.
